// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : shared 640x480@60 raster constants and coordinate type
// Rev 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int C_DIV         = 4;
  localparam int C_H_TOTAL     = 800;
  localparam int C_H_SYNC      = 96;
  localparam int C_H_ACT_START = 144;
  localparam int C_H_ACT_END   = 783;
  localparam int C_V_TOTAL     = 525;
  localparam int C_V_SYNC      = 2;
  localparam int C_V_ACT_START = 35;
  localparam int C_V_ACT_END   = 514;
  localparam int C_V_TICK_LINE = 515;

  // Inclusive range test on coordinates.
  function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_en_divider.sv
`default_nettype none
// ============================================================================
// clk_en_divider : one-cycle enable pulse every DIV clocks (DIV >= 2)
// Rev 1.0
// ============================================================================
module clk_en_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic en_out
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_en;

  always_comb begin
    w_cnt_next = (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
  end

  // Enable is registered so it is high exactly while the count sits at DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_en  <= (w_cnt_next == C_LAST);
    end
  end

  assign en_out = r_en;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : VGA raster counters, registered sync/bright decodes, ticks
// Rev 1.0
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV         = C_DIV,
  parameter int H_TOTAL     = C_H_TOTAL,
  parameter int H_SYNC      = C_H_SYNC,
  parameter int H_ACT_START = C_H_ACT_START,
  parameter int H_ACT_END   = C_H_ACT_END,
  parameter int V_TOTAL     = C_V_TOTAL,
  parameter int V_SYNC      = C_V_SYNC,
  parameter int V_ACT_START = C_V_ACT_START,
  parameter int V_ACT_END   = C_V_ACT_END,
  parameter int V_TICK_LINE = C_V_TICK_LINE
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pixel_en,
  output logic [COORD_W-1:0] hCount,
  output logic [COORD_W-1:0] vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam coord_t C_H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t C_V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t C_H_SYNCE = coord_t'(H_SYNC);
  localparam coord_t C_V_SYNCE = coord_t'(V_SYNC);
  localparam coord_t C_H_ACT_S = coord_t'(H_ACT_START);
  localparam coord_t C_H_ACT_E = coord_t'(H_ACT_END);
  localparam coord_t C_V_ACT_S = coord_t'(V_ACT_START);
  localparam coord_t C_V_ACT_E = coord_t'(V_ACT_END);
  localparam coord_t C_V_TICK  = coord_t'(V_TICK_LINE);

  logic   w_pixel_en;
  logic   w_h_wrap;
  coord_t w_h_next;
  coord_t w_v_next;
  coord_t r_h;
  coord_t r_v;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_bright;
  logic   r_line_tick;
  logic   r_frame_tick;

  clk_en_divider #(
    .DIV (DIV)
  ) u_pix_div (
    .clk    (clk),
    .rst    (rst),
    .en_out (w_pixel_en)
  );

  assign w_h_wrap = w_pixel_en && (r_h == C_H_LAST);

  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_pixel_en) begin
      if (r_h == C_H_LAST) begin
        w_h_next = '0;
        w_v_next = (r_v == C_V_LAST) ? '0 : r_v + coord_t'(1);
      end else begin
        w_h_next = r_h + coord_t'(1);
      end
    end
  end

  // Decodes are taken from the next-state counters so they line up with the
  // registered counters in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h          <= '0;
      r_v          <= '0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_bright     <= 1'b0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_h          <= w_h_next;
      r_v          <= w_v_next;
      r_hsync      <= (w_h_next >= C_H_SYNCE);
      r_vsync      <= (w_v_next >= C_V_SYNCE);
      r_bright     <= in_window(w_h_next, C_H_ACT_S, C_H_ACT_E) &&
                      in_window(w_v_next, C_V_ACT_S, C_V_ACT_E);
      r_line_tick  <= w_h_wrap;
      r_frame_tick <= w_h_wrap && (w_v_next == C_V_TICK);
    end
  end

  assign pixel_en   = w_pixel_en;
  assign hCount     = r_h;
  assign vCount     = r_v;
  assign hSync      = r_hsync;
  assign vSync      = r_vsync;
  assign bright     = r_bright;
  assign line_tick  = r_line_tick;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster timing that the pong renderer and game logic consume: hCount, vCount, bright, hSync, vSync.
- Also produces a pixel-rate enable and per-line and per-frame strobes, so paddle and ball logic can update once per frame instead of every system clock.
- Sits between the 100 MHz board clock and vga_bitchange / the VGA connector.
- 640x480 at 60 Hz, 25 MHz pixel rate derived by clock enable (no second clock domain).

Parameters:
- DIV, 4: system clocks per pixel.
- H_TOTAL, 800: pixels per line.
- H_SYNC, 96: hSync low while hCount < H_SYNC.
- H_ACT_START, 144: first visible column.
- H_ACT_END, 783: last visible column, inclusive.
- V_TOTAL, 525: lines per frame.
- V_SYNC, 2: vSync low while vCount < V_SYNC.
- V_ACT_START, 35: first visible line.
- V_ACT_END, 514: last visible line, inclusive.
- V_TICK_LINE, 515: line whose start raises frame_tick.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- pixel_en  out  1  one-clk pulse every DIV clks; counters advance on it.
- hCount  out  10  horizontal position, 0..H_TOTAL-1.
- vCount  out  10  vertical position, 0..V_TOTAL-1.
- hSync  out  1  horizontal sync, active low.
- vSync  out  1  vertical sync, active low.
- bright  out  1  high inside the visible window.
- line_tick  out  1  one-clk pulse at start of each line.
- frame_tick  out  1  one-clk pulse at start of line V_TICK_LINE (start of vertical blanking).

Behaviour:
- Only clk is used. Reset is synchronous and active-high, sampled on the clk rising edge; it takes effect on any cycle, including mid-line or mid-frame.
- Reset values: div counter 0, pixel_en 0, hCount 0, vCount 0, hSync 0, vSync 0, bright 0, line_tick 0, frame_tick 0.
  - hSync and vSync are 0 at reset because counter 0 lies inside both sync pulses.
- Divider:
  - Counts 0..DIV-1 and wraps.
  - pixel_en is high exactly in the clk cycle where the divider equals DIV-1.
  - After rst drops, the first pixel_en is the 4th clk cycle (divider values 0,1,2,3).
- Counters update only on clk edges where pixel_en=1:
  - hCount = H_TOTAL-1 wraps to 0; otherwise it increments.
  - vCount increments only on that hCount wrap.
  - vCount = V_TOTAL-1 with hCount wrap: both go to 0, i.e. (799,524) -> (0,0).
  - Each (hCount, vCount) value is held for exactly DIV clks.
- Decodes: hSync, vSync and bright must equal the decode of the current hCount/vCount in every clk cycle, with zero skew. Implement them as registered outputs computed from next-state counters so they are glitch-free.
  - hSync = (hCount >= H_SYNC).
  - vSync = (vCount >= V_SYNC).
  - bright = H_ACT_START <= hCount <= H_ACT_END and V_ACT_START <= vCount <= V_ACT_END.
- line_tick: high for exactly the first clk cycle in which hCount=0; never high during reset.
  - After reset releases, the first line_tick occurs at the first hCount wrap, not at the reset value 0.
- frame_tick:
  - High for exactly the first clk cycle in which hCount=0 and vCount=V_TICK_LINE.
  - Once per frame, coincident with that line's line_tick.
- Timing totals:
  - Frame = 800*525*4 = 1,680,000 clks.
  - Line = 3200 clks.
- Widths: all counter compares are 10-bit unsigned; no value may exceed 799 (h) or 524 (v).

Decomposition:
- Package vga_timing_pkg holds the timing constants (H_*/V_* defaults, DIV) and the 10-bit coordinate width; vga_bitchange and the ball/score logic share them.
- One sub-module, clk_en_divider (param DIV; ports clk, rst, en_out), generates pixel_en and is reusable for a game-tick divider.

Test Plan:
- Reset release:
  - Hold rst 10 clks, release.
  - All outputs 0 until pixel_en first rises on clk 4.
  - hCount becomes 1 on the clk after it.
  - hSync stays low through hCount 95 and goes high exactly when hCount=96.
- Line wrap:
  - Run to hCount=799, vCount=0.
  - After 4 clks: hCount=0, vCount=1, line_tick high exactly 1 clk, frame_tick low.
- Visible window:
  - Sweep one full frame.
  - bright high iff hCount 144..783 and vCount 35..514.
  - Count of bright clk cycles = 640*480*4 = 1,228,800.
- Frame boundary:
  - At (799,524) plus 4 clks the counters go to (0,0) and vSync goes low.
  - vSync low for exactly 2 lines = 6400 clks.
  - frame_tick interval measured = 1,680,000 clks, with one pulse at (0,515).
- Mid-frame reset:
  - Assert rst for 1 clk at (400,300), divider=2.
  - Next cycle all outputs at reset values.
  - Timing restarts with the first pixel_en 4 clks after rst low; no spurious line_tick or frame_tick.
- Sync periods:
  - Measure hSync period 3200 clks with low width 384 clks.
  - Measure vSync period 1,680,000 clks.
